// File: rtl/card_pkg.sv
// Shared types and helpers for the card pair tracker.
package card_pkg;

  typedef enum logic [1:0] {IDLE, ONE, COMPARE, HOLD} state_e;

  localparam int N_CARDS_DEF = 16;
  localparam int SYM_W_DEF   = 4;
  // Widest deck/symbol the helper can slice (64 cards x 16-bit symbols).
  localparam int MAX_DECK_W  = 1024;
  localparam int MAX_SYM_W   = 16;

  function automatic logic [MAX_SYM_W-1:0] sym_at(input logic [MAX_DECK_W-1:0] deck,
                                                  input int unsigned idx,
                                                  input int unsigned sym_w);
    logic [MAX_SYM_W-1:0] mask;
    mask = (MAX_SYM_W'(1) << sym_w) - MAX_SYM_W'(1);
    return MAX_SYM_W'(deck >> (idx * sym_w)) & mask;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that pulses expire on the enabled cycle in which it sits at zero.
module hold_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                        cnt_q <= '0;
    else if (load)                     cnt_q <= load_val;
    else if (dec_en && cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
  end

  assign expire = dec_en && (cnt_q == '0);
endmodule

// File: rtl/card_pair_tracker.sv
// Board state for the memory game: accepts picks, evaluates pairs, locks
// matches and flips mismatches back after a hold time.
module card_pair_tracker
  import card_pkg::*;
#(
  parameter int N_CARDS     = N_CARDS_DEF,
  parameter int IDX_W       = 8,
  parameter int SYM_W       = SYM_W_DEF,
  parameter int HOLD_CYCLES = 25_000_000,
  localparam int PW         = $clog2(N_CARDS/2+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     new_game,
  input  logic [N_CARDS*SYM_W-1:0] deck_symbols,
  input  logic                     pick_valid,
  input  logic [IDX_W-1:0]         pick_idx,
  output logic                     pick_ready,
  output logic                     pick_reject,
  output logic [N_CARDS-1:0]       face_up,
  output logic [N_CARDS-1:0]       matched,
  output logic                     pair_done,
  output logic                     pair_match,
  output logic [PW-1:0]            pairs_found,
  output logic                     all_matched
);
  localparam int CW    = $clog2(N_CARDS);
  localparam int CNT_W = $clog2(HOLD_CYCLES+1);
  localparam logic [IDX_W:0] NC   = (IDX_W+1)'(N_CARDS);
  localparam logic [PW-1:0]  HALF = PW'(N_CARDS/2);

  state_e               state_q, state_d;
  logic [N_CARDS-1:0]   face_up_q, face_up_d, matched_q, matched_d;
  logic [CW-1:0]        sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [PW-1:0]        pairs_q, pairs_d;
  logic                 reject_q, reject_d, done_q, done_d, pm_q, pm_d, all_q, all_d;
  logic                 legal, accept, sym_eq, tmr_load, tmr_dec, tmr_expire;
  logic [CW-1:0]        idx_c;

  assign idx_c      = pick_idx[CW-1:0];
  assign pick_ready = (state_q == IDLE) || (state_q == ONE);
  assign legal      = ({1'b0, pick_idx} < NC) && !face_up_q[idx_c] && !matched_q[idx_c];
  assign accept     = pick_valid && pick_ready && legal;
  assign sym_eq     = sym_at(MAX_DECK_W'(deck_symbols), 32'(sel_a_q), SYM_W)
                   == sym_at(MAX_DECK_W'(deck_symbols), 32'(sel_b_q), SYM_W);

  hold_timer #(.CNT_W(CNT_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CNT_W'(HOLD_CYCLES-1)),
    .dec_en   (tmr_dec),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    face_up_d = face_up_q;
    matched_d = matched_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    pairs_d   = pairs_q;
    reject_d  = pick_valid && pick_ready && !legal;
    done_d    = 1'b0;
    pm_d      = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        face_up_d[idx_c] = 1'b1;
        sel_a_d          = idx_c;
        state_d          = ONE;
      end
      ONE: if (accept) begin
        face_up_d[idx_c] = 1'b1;
        sel_b_d          = idx_c;
        state_d          = COMPARE;
      end
      COMPARE: begin
        done_d = 1'b1;
        pm_d   = sym_eq;
        if (sym_eq) begin
          matched_d[sel_a_q] = 1'b1;
          matched_d[sel_b_q] = 1'b1;
          pairs_d            = pairs_q + PW'(1);
          state_d            = IDLE;
        end else begin
          tmr_load = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        tmr_dec = 1'b1;
        if (tmr_expire) begin
          face_up_d[sel_a_q] = 1'b0;
          face_up_d[sel_b_q] = 1'b0;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    all_d = (pairs_d == HALF);
  end

  // new_game shares the reset path so a fresh board looks identical to power-up.
  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      state_q   <= IDLE;
      face_up_q <= '0;
      matched_q <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      pairs_q   <= '0;
      reject_q  <= 1'b0;
      done_q    <= 1'b0;
      pm_q      <= 1'b0;
      all_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      face_up_q <= face_up_d;
      matched_q <= matched_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      pairs_q   <= pairs_d;
      reject_q  <= reject_d;
      done_q    <= done_d;
      pm_q      <= pm_d;
      all_q     <= all_d;
    end
  end

  assign face_up     = face_up_q;
  assign matched     = matched_q;
  assign pick_reject = reject_q;
  assign pair_done   = done_q;
  assign pair_match  = pm_q;
  assign pairs_found = pairs_q;
  assign all_matched = all_q;
endmodule

// File: tb/tb_card_pair_tracker.sv
// Bench for card_pair_tracker: vector table, full-game sequence, random vs model.
module tb_card_pair_tracker;
  localparam int N    = 16;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, new_game = 1'b0, pick_valid = 1'b0;
  logic [7:0]    pick_idx = '0;
  logic [N*4-1:0] deck;
  logic          pick_ready, pick_reject, pair_done, pair_match, all_matched;
  logic [N-1:0]  face_up, matched;
  logic [3:0]    pairs_found;

  int checks = 0, failures = 0;

  card_pair_tracker #(.N_CARDS(N), .IDX_W(8), .SYM_W(4), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .deck_symbols(deck),
    .pick_valid(pick_valid), .pick_idx(pick_idx), .pick_ready(pick_ready),
    .pick_reject(pick_reject), .face_up(face_up), .matched(matched),
    .pair_done(pair_done), .pair_match(pair_match), .pairs_found(pairs_found),
    .all_matched(all_matched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, ng, pv; logic [7:0] idx;
    logic [15:0] fu, mt; logic rdy, rej, done, pm; logic [3:0] pf;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic r, logic ng, logic pv, logic [7:0] idx, logic [15:0] fu,
                              logic [15:0] mt, logic rdy, logic rej, logic done, logic pm,
                              logic [3:0] pf);
    vec_t v;
    v.r = r; v.ng = ng; v.pv = pv; v.idx = idx; v.fu = fu; v.mt = mt;
    v.rdy = rdy; v.rej = rej; v.done = done; v.pm = pm; v.pf = pf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ng, input logic pv, input logic [7:0] idx);
    @(negedge clk);
    rst_n = r; new_game = ng; pick_valid = pv; pick_idx = idx;
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-card flags plus the list of cards opened this turn.
  logic [15:0] m_fu, m_mt;
  int          open_q[$];
  bit          m_eval;
  int          m_wait, m_pf;
  bit          e_rej, e_done, e_pm;

  task automatic model_step(input logic r, input logic ng, input logic pv, input logic [7:0] idx);
    e_rej = 0; e_done = 0; e_pm = 0;
    if (!r || ng) begin
      m_fu = '0; m_mt = '0; open_q.delete(); m_eval = 0; m_wait = 0; m_pf = 0;
    end else if (open_q.size() == 2 && !m_eval) begin
      e_done = 1;
      e_pm = (open_q[0] / 2 == open_q[1] / 2);
      if (e_pm) begin
        m_mt[open_q[0]] = 1; m_mt[open_q[1]] = 1; m_pf++; open_q.delete();
      end else begin
        m_eval = 1; m_wait = HOLD;
      end
    end else if (m_eval) begin
      m_wait--;
      if (m_wait == 0) begin
        m_fu[open_q[0]] = 0; m_fu[open_q[1]] = 0; open_q.delete(); m_eval = 0;
      end
    end else if (pv) begin
      if (idx < N && !m_fu[idx] && !m_mt[idx]) begin
        m_fu[idx] = 1; open_q.push_back(int'(idx));
      end else e_rej = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) deck[i*4 +: 4] = 4'(i / 2);

    //            r  ng pv idx  face_up   matched   rdy rej dn pm pf
    tv.push_back(mk(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 0,  16'h0001, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 1,  16'h0003, 16'h0000, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,  16'h0003, 16'h0003, 1, 0, 1, 1, 1));
    tv.push_back(mk(1, 0, 1, 20, 16'h0003, 16'h0003, 1, 1, 0, 0, 1));
    tv.push_back(mk(1, 0, 1, 0,  16'h0003, 16'h0003, 1, 1, 0, 0, 1));
    tv.push_back(mk(1, 0, 1, 2,  16'h0007, 16'h0003, 1, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 1, 2,  16'h0007, 16'h0003, 1, 1, 0, 0, 1));
    tv.push_back(mk(1, 0, 1, 5,  16'h0027, 16'h0003, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 0, 0,  16'h0027, 16'h0003, 0, 0, 1, 0, 1));
    tv.push_back(mk(1, 0, 1, 3,  16'h0027, 16'h0003, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 0, 0,  16'h0027, 16'h0003, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 0, 0,  16'h0027, 16'h0003, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 0, 0,  16'h0003, 16'h0003, 1, 0, 0, 0, 1));
    tv.push_back(mk(1, 1, 0, 0,  16'h0000, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 2,  16'h0004, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 6,  16'h0000, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 2,  16'h0004, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 7,  16'h0084, 16'h0000, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,  16'h0084, 16'h0000, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 9,  16'h0200, 16'h0000, 1, 0, 0, 0, 0));

    foreach (tv[k]) begin
      drive(tv[k].r, tv[k].ng, tv[k].pv, tv[k].idx);
      chk($sformatf("v%0d face_up", k),     32'(face_up),     32'(tv[k].fu));
      chk($sformatf("v%0d matched", k),     32'(matched),     32'(tv[k].mt));
      chk($sformatf("v%0d pick_ready", k),  32'(pick_ready),  32'(tv[k].rdy));
      chk($sformatf("v%0d pick_reject", k), 32'(pick_reject), 32'(tv[k].rej));
      chk($sformatf("v%0d pair_done", k),   32'(pair_done),   32'(tv[k].done));
      chk($sformatf("v%0d pair_match", k),  32'(pair_match),  32'(tv[k].pm));
      chk($sformatf("v%0d pairs_found", k), 32'(pairs_found), 32'(tv[k].pf));
      chk($sformatf("v%0d all_matched", k), 32'(all_matched), 32'(0));
    end

    // Full game: every pair in order, then one more pick must bounce.
    drive(0, 0, 0, 0);
    for (int p = 0; p < N / 2; p++) begin
      drive(1, 0, 1, 8'(2 * p));
      drive(1, 0, 1, 8'(2 * p + 1));
      drive(1, 0, 0, 0);
      chk($sformatf("game pair%0d done", p),  32'(pair_done),   32'(1));
      chk($sformatf("game pair%0d match", p), 32'(pair_match),  32'(1));
      chk($sformatf("game pair%0d found", p), 32'(pairs_found), 32'(p + 1));
    end
    chk("game all_matched", 32'(all_matched), 32'(1));
    chk("game matched",     32'(matched),     32'hFFFF);
    chk("game face_up",     32'(face_up),     32'hFFFF);
    drive(1, 0, 1, 3);
    chk("game late reject", 32'(pick_reject), 32'(1));
    chk("game late ready",  32'(pick_ready),  32'(1));

    // Randomised run against the model.
    drive(0, 0, 0, 0);
    model_step(0, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      logic r, ng, pv;
      logic [7:0] idx;
      r   = ($urandom_range(0, 199) != 0);
      ng  = ($urandom_range(0, 149) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      idx = 8'($urandom_range(0, 19));
      drive(r, ng, pv, idx);
      model_step(r, ng, pv, idx);
      chk("rnd face_up",     32'(face_up),     32'(m_fu));
      chk("rnd matched",     32'(matched),     32'(m_mt));
      chk("rnd pick_ready",  32'(pick_ready),  32'(open_q.size() < 2));
      chk("rnd pick_reject", 32'(pick_reject), 32'(e_rej));
      chk("rnd pair_done",   32'(pair_done),   32'(e_done));
      chk("rnd pair_match",  32'(pair_match),  32'(e_pm));
      chk("rnd pairs_found", 32'(pairs_found), 32'(m_pf));
      chk("rnd all_matched", 32'(all_matched), 32'(m_pf == N / 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/card_pair_tracker.md
Name: card_pair_tracker

Overview:
- Parametrised successor to the per-card flip-back logic of the memory-game board.
- Owns the face-up and matched state of N_CARDS cards and accepts player picks.
- Compares each pair of picks by symbol, locks matched pairs, and flips mismatched pairs back to face-down after a programmable hold time.
- Sits between the pick/input decoder and the VGA card renderer.

Parameters:
- N_CARDS, 16, number of cards on the board (even, 4..64).
- IDX_W, 8, width of the pick index (byte index, as the board already uses).
- SYM_W, 4, width of one card symbol.
- HOLD_CYCLES, 25_000_000, cycles a mismatched pair stays face-up (0.5 s at 50 MHz); must be ≥1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- new_game  in  1  synchronous clear of all board state; same effect as reset.
- deck_symbols  in  N_CARDS*SYM_W  symbol of card i in bits [i*SYM_W +: SYM_W]; must be stable during a game.
- pick_valid  in  1  a pick is offered this cycle.
- pick_idx  in  IDX_W  index of the picked card.
- pick_ready  out  1  tracker can accept a pick (IDLE or ONE state).
- pick_reject  out  1  one-cycle pulse: the offered pick was illegal and ignored.
- face_up  out  N_CARDS  card i is shown face-up.
- matched  out  N_CARDS  card i is permanently matched.
- pair_done  out  1  one-cycle pulse: a pair was evaluated.
- pair_match  out  1  valid with pair_done; 1 = symbols equal.
- pairs_found  out  $clog2(N_CARDS/2+1)  count of matched pairs.
- all_matched  out  1  high when pairs_found == N_CARDS/2.

Behaviour:
- Reset (rst_n=0 at a clock edge) or new_game=1:
  - State goes to IDLE.
  - face_up, matched, pairs_found, pick_reject, pair_done, pair_match, all_matched = 0; pick_ready = 1.
  - Takes effect even mid-HOLD or mid-COMPARE. rst_n has priority over new_game.
- A pick is accepted when pick_valid && pick_ready && legal.
  - Legal means all of: pick_idx < N_CARDS; !face_up[idx]; !matched[idx].
  - Illegal pick while pick_ready=1: pick_reject pulses the next cycle. No state change.
  - pick_valid while pick_ready=0: silently ignored, no reject.
- FSM states: IDLE, ONE, COMPARE, HOLD.
  - IDLE: on an accepted pick, set face_up[idx], store sel_a=idx, go to ONE.
  - ONE: on an accepted pick, set face_up[idx], store sel_b=idx, go to COMPARE. Picking sel_a again is illegal because it is already face-up.
  - COMPARE (exactly 1 cycle): pair_done=1 and pair_match=(sym[sel_a]==sym[sel_b]) are registered, so they are visible the cycle after COMPARE.
    - Match: set matched[sel_a] and matched[sel_b], keep both face-up, increment pairs_found, go to IDLE.
    - Mismatch: load the hold counter with HOLD_CYCLES-1, go to HOLD.
  - HOLD: decrement the counter each cycle. When it reaches 0, clear face_up[sel_a] and face_up[sel_b] in the same cycle and go to IDLE. pick_ready=0 throughout HOLD.
- Latency:
  - Pick to face_up visible: 1 cycle.
  - Second pick to pair_done: 2 cycles.
  - Mismatch flip-back: face_up clears HOLD_CYCLES cycles after the COMPARE cycle.
- all_matched is registered. Once set, further picks are all illegal, because every card is already face-up and matched.
- Hold counter width is $clog2(HOLD_CYCLES+1). The counter does not wrap.
- face_up and matched only change through the rules above. matched[i] implies face_up[i].

Decomposition:
- Shared package card_pkg holds:
  - the state enum typedef (IDLE, ONE, COMPARE, HOLD);
  - default constants N_CARDS_DEF=16, SYM_W_DEF=4;
  - function sym_at(deck, idx) for the symbol slice.
- One natural sub-module: hold_timer. It takes a load, a load value and a decrement enable, and outputs an expiry pulse. Its reset is also synchronous and active-low.

Test Plan (bench uses HOLD_CYCLES=4, N_CARDS=16, symbols = i/2):
- Reset: drive rst_n=0 for 2 cycles. Expect face_up=0, matched=0, pairs_found=0, pick_ready=1. Assert rst_n=0 again mid-HOLD: the state clears on the next edge.
- Match: pick 0, then 1. Expect face_up bits 0,1 set; pair_done=1 and pair_match=1 two cycles after pick 1; matched=0x0003; pairs_found=1.
- Mismatch: pick 2, then 5. Expect pair_match=0; face_up[2] and face_up[5] held for 4 cycles, then both cleared; pick_ready=0 during hold, then 1.
- Illegal picks: pick_idx=20 → pick_reject pulse. Re-pick the face-up card 2 while in ONE → reject. Pick matched card 0 → reject. State unchanged in every case.
- Full game: pick all 8 matching pairs. Expect pairs_found=8, all_matched=1, matched=0xFFFF. The next pick is rejected.
- new_game: assert during ONE with face_up=0x0004. Expect all outputs cleared next cycle and state IDLE.
